// File: rtl/instr_fetch_unit.sv
// PC register and instruction fetch stage feeding the main control decoder.
// Define FETCH_INSTRET_EN to add the retired-instruction counter port instret.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        retire,
   input  logic        branch,
   input  logic        jump,
   input  logic        zero
`ifdef FETCH_INSTRET_EN
   ,
   output logic [31:0] instret
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_HOLD
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] br_off;
   logic [31:0] next_pc;

   assign pc_plus4  = pc_q + 32'd4;
   assign br_off    = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
   assign pc        = pc_q;
   assign imem_addr = pc_q;
   assign instr     = instr_q;
   assign opcode    = instr_q[31:26];

   // Jump takes priority over a taken branch.
   always_comb begin
      next_pc = pc_plus4;
      if (jump) begin
         next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      end else if (branch && zero) begin
         next_pc = pc_plus4 + br_off;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = S_HOLD;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            instr_valid = 1'b1;
            if (retire) begin
               pc_d    = next_pc;
               state_d = S_FETCH;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

`ifdef FETCH_INSTRET_EN
   logic [31:0] instret_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         instret_q <= 32'd0;
      end else if (state_q == S_HOLD && retire) begin
         instret_q <= instret_q + 32'd1;
      end
   end

   assign instret = instret_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a memory responder drives acks,
// expected fetches are queued on ack and checked when instr_valid rises.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        retire;
   logic        branch;
   logic        jump;
   logic        zero;
`ifdef FETCH_INSTRET_EN
   logic [31:0] instret;
`endif

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] model_pc = 32'd0;
   logic [31:0] retires  = 32'd0;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .imem_ack   (imem_ack),
      .instr      (instr),
      .opcode     (opcode),
      .instr_valid(instr_valid),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .retire     (retire),
      .branch     (branch),
      .jump       (jump),
      .zero       (zero)
`ifdef FETCH_INSTRET_EN
      ,
      .instret    (instret)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_fetch(input logic [31:0] data, input int delay,
                           input int hold, input logic br, input logic jp,
                           input logic zr, input logic [31:0] nxt);
      int   n = 0;
      exp_t e;
      while (!imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!imem_req) begin
         chk("req_timeout", 32'd0, 32'd1);
         return;
      end
      chk("fetch_addr", imem_addr, model_pc);
      for (int d = 0; d < delay; d++) begin
         imem_ack   = 1'b0;
         imem_rdata = 32'hDEAD_BEEF;
         retire     = 1'b1;
         jump       = 1'b1;
         @(negedge clk);
         chk("wait_req", {31'd0, imem_req}, 32'd1);
         chk("wait_addr", imem_addr, model_pc);
         chk("wait_valid", {31'd0, instr_valid}, 32'd0);
      end
      retire     = 1'b0;
      jump       = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = data;
      sb_q.push_back('{pc: model_pc, instr: data});
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("hold_req", {31'd0, imem_req}, 32'd0);
      if (sb_q.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
         return;
      end
      e = sb_q.pop_front();
      chk("instr", instr, e.instr);
      chk("opcode", {26'd0, opcode}, {26'd0, e.instr[31:26]});
      chk("pc", pc, e.pc);
      chk("pc_plus4", pc_plus4, e.pc + 32'd4);
      for (int h = 0; h < hold; h++) begin
         imem_ack   = 1'b1;
         imem_rdata = 32'h1234_5678;
         branch     = 1'b1;
         jump       = 1'b1;
         zero       = 1'b1;
         @(negedge clk);
         chk("hold_instr", instr, e.instr);
         chk("hold_pc", pc, e.pc);
         chk("hold_stay", {31'd0, instr_valid}, 32'd1);
      end
      imem_ack = 1'b0;
      retire   = 1'b1;
      branch   = br;
      jump     = jp;
      zero     = zr;
      @(negedge clk);
      retire   = 1'b0;
      branch   = 1'b0;
      jump     = 1'b0;
      zero     = 1'b0;
      model_pc = nxt;
      retires  = retires + 32'd1;
      chk("refetch_req", {31'd0, imem_req}, 32'd1);
      chk("next_addr", imem_addr, nxt);
      chk("clr_valid", {31'd0, instr_valid}, 32'd0);
`ifdef FETCH_INSTRET_EN
      chk("instret", instret, retires);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset      = 1'b1;
      imem_ack   = 1'b0;
      imem_rdata = 32'd0;
      retire     = 1'b0;
      branch     = 1'b0;
      jump       = 1'b0;
      zero       = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_pc", pc, 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
      chk("rst_pc4", pc_plus4, 32'd4);
`ifdef FETCH_INSTRET_EN
      chk("rst_instret", instret, 32'd0);
`endif
      reset = 1'b0;
      @(negedge clk);
      chk("first_req", {31'd0, imem_req}, 32'd1);

      do_fetch(32'h8C08_0004, 0, 1, 1'b0, 1'b0, 1'b0, 32'h0000_0004);
      do_fetch(32'h2000_0001, 3, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0008);
      do_fetch(32'h0800_0010, 1, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0040);
      do_fetch(32'h1000_FFFF, 0, 0, 1'b1, 1'b0, 1'b1, 32'h0000_0040);
      do_fetch(32'h1000_FFFF, 0, 1, 1'b1, 1'b0, 1'b0, 32'h0000_0044);
      do_fetch(32'h0800_0000, 2, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0000);
      do_fetch(32'h1000_FFFE, 0, 0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
      do_fetch(32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
      do_fetch(32'h0BFF_FFFF, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0FFF_FFFC);
      do_fetch(32'h1000_0005, 0, 0, 1'b1, 1'b0, 1'b0, 32'h1000_0000);
      do_fetch(32'h0800_0010, 1, 1, 1'b1, 1'b1, 1'b1, 32'h1000_0040);
      do_fetch(32'h1000_0002, 0, 0, 1'b1, 1'b0, 1'b1, 32'h1000_004C);

      // Reset in WAIT with acks in the reset cycle and the IDLE cycle.
      imem_ack = 1'b0;
      @(negedge clk);
      chk("pre_rst_wait", {31'd0, imem_req}, 32'd1);
      reset      = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'hAAAA_AAAA;
      @(negedge clk);
      chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
      chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("mid_rst_instr", instr, 32'd0);
      chk("mid_rst_pc", pc, 32'd0);
`ifdef FETCH_INSTRET_EN
      chk("mid_rst_instret", instret, 32'd0);
`endif
      reset = 1'b0;
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      chk("post_rst_req", {31'd0, imem_req}, 32'd1);
      chk("post_rst_addr", imem_addr, 32'd0);
      chk("post_rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("post_rst_instr", instr, 32'd0);
      model_pc = 32'd0;
      retires  = 32'd0;
      do_fetch(32'h8C08_0004, 1, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0004);

      chk("sb_drained", sb_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
